// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared FSM states, port ids and default memory depth for dmem_arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int DEF_MEM_DEPTH = 256;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; a tie goes to the port that did not win last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);
  assign win = &req ? ~last : (req[1] ? PORT1 : PORT0);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-ported data memory between two requesters.
// Optional DMEM_ARB_RANGE_CHECK_EN blocks out-of-range accesses and reports them on err0/err1.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic CHECK = 1'b1;
`else
  localparam logic CHECK = 1'b0;
`endif
  state_t state, next;
  logic ptr, owner, win, cmd_we, oor, issue, resp, rv;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  rr_arb2 u_arb (.req({req1, req0}), .last(ptr), .win(win));
  // Range check is folded away when disabled, so every address reaches memory.
  assign oor = CHECK && (cmd_addr >= ADDR_WIDTH'(MEM_DEPTH));
  assign mem_addr = cmd_addr;
  assign mem_wdata = cmd_wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= PORT1;
      owner     <= PORT0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      state <= next;
      if (state == IDLE && (req0 || req1)) begin
        ptr       <= win;
        owner     <= win;
        cmd_we    <= win ? we1 : we0;
        cmd_addr  <= win ? addr1 : addr0;
        cmd_wdata <= win ? wdata1 : wdata0;
      end
    end
  end
  always_comb begin
    issue     = state == ISSUE;
    resp      = state == RESP;
    rv        = resp && !cmd_we;
    next      = state == IDLE ? ((req0 || req1) ? ISSUE : IDLE) :
                issue ? ((cmd_we && !oor) ? IDLE : RESP) : IDLE;
    mem_read  = issue && !cmd_we && !oor;
    mem_write = issue && cmd_we && !oor;
    gnt0      = issue && owner == PORT0;
    gnt1      = issue && owner == PORT1;
    rvalid0   = rv && owner == PORT0;
    rvalid1   = rv && owner == PORT1;
    err0      = resp && oor && owner == PORT0;
    err1      = resp && oor && owner == PORT1;
    rdata0    = (rvalid0 && !oor) ? mem_rdata : '0;
    rdata1    = (rvalid1 && !oor) ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a transaction-level memory/arbitration model.
// Honours DMEM_ARB_RANGE_CHECK_EN the same way as the design.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t e, pe;
  logic pend = 1'b0;
  logic [31:0] ref_mem [256];
  logic model_last = 1'b1;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: memory of 256 words indexed by the low address byte; out-of-range
  // accesses are suppressed only when the range check is built in.
  task automatic model_txn(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t t;
    t.port = p; t.we = w; t.addr = a; t.wdata = d; t.rdata = '0;
    t.err = CHK && (a >= 32'd256);
    if (w && !t.err) ref_mem[a[7:0]] = d;
    if (!w && !t.err) t.rdata = ref_mem[a[7:0]];
    q.push_back(t);
  endtask

  always @(negedge clk) begin
    if (reset) pend = 1'b0;
    else begin
      chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
      if (pend) begin
        chk("rvalid", 32'({rvalid1, rvalid0}), pe.we ? 32'd0 : (pe.port ? 32'd2 : 32'd1));
        chk("err", 32'({err1, err0}), pe.err ? (pe.port ? 32'd2 : 32'd1) : 32'd0);
        chk("rdata", pe.port ? rdata1 : rdata0, pe.we ? 32'd0 : pe.rdata);
        chk("rdata_other", pe.port ? rdata0 : rdata1, 32'd0);
        pend = 1'b0;
      end else
        chk("idle_resp", 32'({rvalid0, rvalid1, err0, err1, |rdata0, |rdata1}), 32'd0);
      if (gnt0 || gnt1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gnt: got gnt0=%0b gnt1=%0b expected none", gnt0, gnt1);
        end else begin
          e = q.pop_front();
          chk("gnt_port", 32'(gnt1), 32'(e.port));
          chk("mem_write", 32'(mem_write), 32'(e.we && !e.err));
          chk("mem_read", 32'(mem_read), 32'(!e.we && !e.err));
          if (!e.err) chk("mem_addr", mem_addr, e.addr);
          if (e.we && !e.err) chk("mem_wdata", mem_wdata, e.wdata);
          if (!e.we || e.err) begin
            pe = e;
            pend = 1'b1;
          end
        end
      end else
        chk("idle_strobes", 32'({mem_read, mem_write}), 32'd0);
    end
  end

  task automatic round(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic g0, g1, s0, s1, first;
    int n;
    if (r0 && r1) begin
      first = ~model_last;
      if (first) begin model_txn(1'b1, w1, a1, d1); model_txn(1'b0, w0, a0, d0); end
      else begin model_txn(1'b0, w0, a0, d0); model_txn(1'b1, w1, a1, d1); end
      model_last = ~first;
    end else if (r0) begin
      model_txn(1'b0, w0, a0, d0); model_last = 1'b0;
    end else if (r1) begin
      model_txn(1'b1, w1, a1, d1); model_last = 1'b1;
    end
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    g0 = !r0; g1 = !r1; n = 0;
    while (!(g0 && g1) && n < 20) begin
      @(negedge clk);
      s0 = gnt0; s1 = gnt1;
      @(posedge clk); #1;
      if (s0) begin req0 = 1'b0; g0 = 1'b1; end
      if (s1) begin req1 = 1'b0; g1 = 1'b1; end
      n++;
    end
    checks++;
    if (!(g0 && g1)) begin
      errors++;
      $display("FAIL round_timeout: got granted0=%0b granted1=%0b expected both", g0, g1);
      req0 = 1'b0; req1 = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[5] = 32'hCAFE0001; ref_mem[5] = 32'hCAFE0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write}), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_rdata", rdata0 | rdata1, 32'd0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    round(1, 0, 32'd5, 0, 0, 0, 0, 0);
    round(0, 0, 0, 0, 1, 1, 32'd200, 32'h12345678);
    round(0, 0, 0, 0, 1, 0, 32'd200, 0);
    for (int i = 0; i < 3; i++)
      round(1, 1, 32'(i), 32'h1000 + 32'(i), 1, 0, 32'(i), 0);
    model_txn(1'b0, 1'b0, 32'd7, 0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (gnt0) break;
      n++;
    end
    checks++;
    if (n >= 10) begin errors++; $display("FAIL reset_read_gnt: got no gnt0 expected gnt0"); end
    #1 reset = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    chk("midreset_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write}), 32'd0);
    chk("midreset_mem_addr", mem_addr, 32'd0);
    chk("midreset_rdata", rdata0 | rdata1, 32'd0);
    @(negedge clk); #1 reset = 1'b0;
    model_last = 1'b1;
    @(posedge clk); #1;
    round(1, 0, 32'd5, 0, 1, 0, 32'd200, 0);
    round(1, 0, 32'd300, 0, 0, 0, 0, 0);
    round(1, 1, 32'd300, 32'hDEADBEEF, 0, 0, 0, 0);
    round(1, 0, 32'd44, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [31:0] b;
      sel = $urandom_range(1, 3);
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 400)) : 32'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 400)) : 32'($urandom_range(0, 15));
      round(sel[0], 1'($urandom_range(0, 1)), a, $urandom,
            sel[1], 1'($urandom_range(0, 1)), b, $urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("no_pending", 32'(pend), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
